// File: rtl/apb_wait_slave.sv
// APB completer with a DEPTH x DATA_W register file and WAIT_STATES wait cycles per access.
// Build option: define APB_SLVERR_EN to flag out-of-range addresses with PSLVERR instead of wrapping them.
module apb_wait_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              dbg_state
);

  // Handshake: a transfer starts with a SETUP cycle (PSEL=1, PENABLE=0) seen in IDLE and
  // completes on the rising edge where PSEL=1, PENABLE=1 and PREADY=1; dropping PSEL
  // while in ACCESS abandons the transfer without touching the register file.

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_CNT = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W+1)'(DEPTH);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_wait_slave: WAIT_STATES must be in 0..15");
  end
  if (IDX_W > ADDR_W) begin : g_bad_addr
    $error("apb_wait_slave: ADDR_W too narrow for DEPTH");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               latch, commit;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  regs [DEPTH];
  logic [IDX_W-1:0]   idx;
  logic               hit;

  assign idx = addr_q[IDX_W-1:0];

`ifdef APB_SLVERR_EN
  logic in_range;
  assign in_range = ({1'b0, addr_q} < DEPTH_A);
  assign hit      = in_range;
  assign PSLVERR  = PREADY & ~in_range;
`else
  // Address wraps onto the low index bits; the rest of the latched address is don't-care.
  if (DEPTH != (1 << IDX_W)) begin : g_bad_depth
    $error("apb_wait_slave: DEPTH must be a power of two without APB_SLVERR_EN");
  end
  logic unused_addr;
  assign unused_addr = ^{addr_q, DEPTH_A};
  assign hit         = 1'b1;
  assign PSLVERR     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = WAIT_CNT;
          latch   = 1'b1;
        end
      end
      ACCESS: begin
        // Losing PSEL wins over everything, including the counter hitting zero.
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (PENABLE) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (commit && write_q && hit) begin
      regs[idx] <= wdata_q;
    end
  end

  assign PREADY    = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign PRDATA    = (PREADY && !write_q && hit) ? regs[idx] : '0;
  assign dbg_state = (state_q == ACCESS);

endmodule
